// File: rtl/i2c_oled_slave.sv
// i2c_oled_slave: I2C target for SSD1306-style OLED command/data streams; define I2C_SLAVE_READ_EN to add status reads
module i2c_oled_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       busy,
  input  logic [7:0] status_in
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK, RD, RD_ACK, IGNORE
  } state_t;
`ifdef I2C_SLAVE_READ_EN
  localparam logic RD_EN = 1'b1;
`else
  localparam logic RD_EN = 1'b0;
`endif
  state_t     state_q, state_d;
  logic [2:0] scl_q, sda_q;
  logic [2:0] bit_q, bit_d;
  logic [6:0] sh_q, sh_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       co_q, co_d;
  logic       dcl_q, dcl_d;
  logic       vld_q, vld_d;
  logic [7:0] data_q, data_d;
  logic       dc_q, dc_d;
`ifdef I2C_SLAVE_READ_EN
  logic       rw_q, rw_d;
  logic [7:0] tx_q, tx_d;
`else
  logic       unused_status;
  assign unused_status = ^status_in;
`endif
  logic       scl_rise, scl_fall, start_w, stop_w, last_bit, addr_ok;
  logic [7:0] byte_w;
  // [1] is the synchronized level, [2] its previous value for edge detection
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start_w  = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_w   = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign byte_w   = {sh_q, sda_q[1]};
  assign last_bit = bit_q == 3'd7;
  assign addr_ok  = (byte_w[7:1] == SLAVE_ADDR) && (RD_EN || !byte_w[0]);
  assign sda_oe   = oe_q;
  assign rx_valid = vld_q;
  assign rx_data  = data_q;
  assign rx_dc    = dc_q;
  assign busy     = busy_q;
  // Pad synchronizers; idle bus level is high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end
  // Protocol state: bits sampled on SCL rise, SDA drive changed only on SCL fall
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    co_d    = co_q;
    dcl_d   = dcl_q;
    vld_d   = 1'b0;
    data_d  = data_q;
    dc_d    = dc_q;
`ifdef I2C_SLAVE_READ_EN
    rw_d    = rw_q;
    tx_d    = tx_q;
`endif
    if (start_w || stop_w) begin
      state_d = start_w ? ADDR : IDLE;
      bit_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR: begin
          sh_d  = byte_w[6:0];
          bit_d = bit_q + 3'd1;
          if (last_bit) begin
            state_d = addr_ok ? ADDR_ACK : IGNORE;
            busy_d  = addr_ok;
`ifdef I2C_SLAVE_READ_EN
            rw_d    = byte_w[0];
`endif
          end
        end
        CTRL: begin
          sh_d  = byte_w[6:0];
          bit_d = bit_q + 3'd1;
          if (last_bit) begin
            state_d = CTRL_ACK;
            co_d    = byte_w[7];
            dcl_d   = byte_w[6];
          end
        end
        DATA: begin
          sh_d  = byte_w[6:0];
          bit_d = bit_q + 3'd1;
          if (last_bit) begin
            state_d = DATA_ACK;
            vld_d   = 1'b1;
            data_d  = byte_w;
            dc_d    = dcl_q;
          end
        end
`ifdef I2C_SLAVE_READ_EN
        RD: bit_d = bit_q + 3'd1;
        RD_ACK: state_d = sda_q[1] ? IGNORE : RD_ACK;
`endif
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        // First fall opens the ACK slot, second fall closes it
        ADDR_ACK, CTRL_ACK, DATA_ACK: begin
          oe_d = ~oe_q;
          if (oe_q) begin
            bit_d   = 3'd0;
            state_d = state_q == ADDR_ACK ? CTRL : state_q == CTRL_ACK ? DATA : co_q ? CTRL : DATA;
`ifdef I2C_SLAVE_READ_EN
            if (state_q == ADDR_ACK && rw_q) begin
              state_d = RD;
              tx_d    = status_in;
              oe_d    = ~status_in[7];
            end
`endif
          end
        end
`ifdef I2C_SLAVE_READ_EN
        // bit_q counts rises; a wrap to 0 means all 8 bits went out
        RD: begin
          oe_d    = bit_q == 3'd0 ? 1'b0 : ~tx_q[3'd7 - bit_q];
          state_d = bit_q == 3'd0 ? RD_ACK : RD;
        end
        // Still here at the fall means the master ACKed: resend the byte
        RD_ACK: begin
          oe_d    = ~tx_q[7];
          bit_d   = 3'd0;
          state_d = RD;
        end
`endif
        default: ;
      endcase
    end
  end
  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      bit_q   <= 3'd0;
      sh_q    <= 7'd0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      co_q    <= 1'b0;
      dcl_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= 8'h00;
      dc_q    <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      rw_q    <= 1'b0;
      tx_q    <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      co_q    <= co_d;
      dcl_q   <= dcl_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
`ifdef I2C_SLAVE_READ_EN
      rw_q    <= rw_d;
      tx_q    <= tx_d;
`endif
    end
  end
endmodule

// File: tb/tb_i2c_oled_slave.sv
// tb_i2c_oled_slave: bit-banged I2C master against a byte-level protocol model
module tb_i2c_oled_slave;
  localparam logic [6:0] ADDR = 7'h3C;
  localparam int P_IDLE = 0, P_ADDR = 1, P_CTRL = 2, P_DATA = 3, P_READ = 4, P_IGN = 5;
`ifdef I2C_SLAVE_READ_EN
  localparam logic RD_EN = 1'b1;
`else
  localparam logic RD_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_line, sda_oe, rx_valid, rx_dc, busy;
  logic [7:0] rx_data;
  logic [7:0] status = 8'hA5;
  int checks = 0, errors = 0, rx_cnt = 0;
  int m_phase = P_IDLE;
  logic m_co = 1'b0, m_dc = 1'b0, m_busy = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic last_dc = 1'b0, prev_vld = 1'b0, master_slot = 1'b0, last_ack = 1'b1;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_oled_slave #(.SLAVE_ADDR(ADDR)) dut (
    .CLK(clk), .RST(rst), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_dc(rx_dc), .busy(busy), .status_in(status)
  );

  // Per-cycle compare: reset outputs, payload stream, held outputs, no drive in master bit slots
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_data = 8'h00;
      last_dc = 1'b0;
      checks++;
      if ({sda_oe, busy, rx_valid} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs got oe/busy/vld=%b expected 000", {sda_oe, busy, rx_valid});
      end
    end
    if (rx_valid) begin
      rx_cnt++;
      checks++;
      if (prev_vld) begin
        errors++;
        $display("FAIL rx_pulse_width got 2+ cycles expected 1");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got %02h dc=%0d expected none", rx_data, rx_dc);
        last_data = rx_data;
        last_dc = rx_dc;
      end else {last_dc, last_data} = exp_q.pop_front();
    end
    prev_vld = rx_valid;
    checks++;
    if (rx_data !== last_data || rx_dc !== last_dc) begin
      errors++;
      $display("FAIL rx_payload got %02h dc=%0d expected %02h dc=%0d", rx_data, rx_dc, last_data, last_dc);
    end
    if (master_slot) begin
      checks++;
      if (sda_oe !== 1'b0) begin
        errors++;
        $display("FAIL oe_in_write_bit got %b expected 0", sda_oe);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Byte-level protocol rules: predicted ACK and payload events
  task automatic model_byte(input logic [7:0] b, output logic ack);
    ack = 1'b1;
    case (m_phase)
      P_ADDR: if (b[7:1] == ADDR && (!b[0] || RD_EN)) begin
        ack = 1'b0;
        m_busy = 1'b1;
        m_phase = b[0] ? P_READ : P_CTRL;
      end else m_phase = P_IGN;
      P_CTRL: begin
        ack = 1'b0;
        m_co = b[7];
        m_dc = b[6];
        m_phase = P_DATA;
      end
      P_DATA: begin
        ack = 1'b0;
        exp_q.push_back({m_dc, b});
        m_phase = m_co ? P_CTRL : P_DATA;
      end
      default: ;
    endcase
  endtask

  task automatic chk_busy();
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic wbit(input logic b);
    sda_m = b;
    master_slot = 1'b1;
    tick(8);
    scl_m = 1'b1;
    tick(16);
    scl_m = 1'b0;
    master_slot = 1'b0;
    tick(8);
  endtask

  task automatic ackslot(input logic exp);
    sda_m = 1'b1;
    tick(8);
    scl_m = 1'b1;
    tick(8);
    last_ack = sda_line;
    check("ack_slot", 32'(sda_line), 32'(exp));
    tick(8);
    scl_m = 1'b0;
    tick(8);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ack;
    model_byte(b, ack);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    ackslot(ack);
    chk_busy();
  endtask

  task automatic pbits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) wbit(b[i]);
  endtask

  task automatic start_c();
    sda_m = 1'b1;
    tick(8);
    scl_m = 1'b1;
    tick(8);
    sda_m = 1'b0;
    tick(8);
    scl_m = 1'b0;
    tick(8);
    m_phase = P_ADDR;
    m_busy = 1'b0;
    chk_busy();
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    tick(8);
    scl_m = 1'b1;
    tick(8);
    sda_m = 1'b1;
    tick(16);
    m_phase = P_IDLE;
    m_busy = 1'b0;
    chk_busy();
  endtask

`ifdef I2C_SLAVE_READ_EN
  task automatic read_byte(input logic mnack, output logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1;
      tick(8);
      scl_m = 1'b1;
      tick(8);
      v[i] = sda_line;
      tick(8);
      scl_m = 1'b0;
      tick(8);
    end
    check("rd_byte", 32'(v), m_phase == P_READ ? 32'(status) : 32'hFF);
    sda_m = mnack;
    tick(8);
    scl_m = 1'b1;
    tick(16);
    scl_m = 1'b0;
    tick(8);
    if (mnack) m_phase = P_IGN;
  endtask
`endif

  initial begin
    logic [7:0] v;
    logic [6:0] a;
    int n0, nb;
    tick(4);
    check("rst_oe", 32'(sda_oe), 32'h0);
    check("rst_data", 32'(rx_data), 32'h0);
    check("rst_dc", 32'(rx_dc), 32'h0);
    rst = 1'b0;
    tick(4);
    // Co=0 command stream
    n0 = rx_cnt;
    start_c();
    send_byte(8'h78);
    check("t1_addr_ack", 32'(last_ack), 32'h0);
    send_byte(8'h00);
    send_byte(8'hAE);
    send_byte(8'hA8);
    stop_c();
    check("t1_count", 32'(rx_cnt - n0), 32'd2);
    check("t1_data", 32'(rx_data), 32'hA8);
    check("t1_dc", 32'(rx_dc), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    // Co=1 single command, then Co=1 single data byte
    n0 = rx_cnt;
    start_c();
    send_byte(8'h78);
    send_byte(8'h80);
    send_byte(8'h81);
    send_byte(8'hC0);
    send_byte(8'h55);
    stop_c();
    check("t2_count", 32'(rx_cnt - n0), 32'd2);
    check("t2_data", 32'(rx_data), 32'h55);
    check("t2_dc", 32'(rx_dc), 32'h1);
    // Wrong address: NACK and silence
    n0 = rx_cnt;
    start_c();
    send_byte(8'h7A);
    check("t3_nack", 32'(last_ack), 32'h1);
    check("t3_busy", 32'(busy), 32'h0);
    send_byte(8'h00);
    send_byte(8'hAE);
    stop_c();
    check("t3_count", 32'(rx_cnt - n0), 32'd0);
    // Partial byte dropped by repeated START
    n0 = rx_cnt;
    start_c();
    send_byte(8'h78);
    send_byte(8'h40);
    pbits(8'hFF, 4);
    start_c();
    send_byte(8'h78);
    send_byte(8'h00);
    send_byte(8'hAF);
    stop_c();
    check("t4_count", 32'(rx_cnt - n0), 32'd1);
    check("t4_data", 32'(rx_data), 32'hAF);
    // Reset in the address ACK slot
    start_c();
    v = 8'h78;
    for (int i = 7; i >= 0; i--) wbit(v[i]);
    sda_m = 1'b1;
    tick(8);
    scl_m = 1'b1;
    tick(8);
    check("t5_ack_driven", 32'(sda_line), 32'h0);
    #2 rst = 1'b1;
    #1;
    check("t5_oe_async", 32'(sda_oe), 32'h0);
    check("t5_busy_async", 32'(busy), 32'h0);
    check("t5_data_async", 32'(rx_data), 32'h0);
    m_phase = P_IDLE;
    m_busy = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);
    scl_m = 1'b0;
    tick(8);
    n0 = rx_cnt;
    send_byte(8'h00);
    check("t5_no_resume", 32'(last_ack), 32'h1);
    send_byte(8'hAE);
    stop_c();
    start_c();
    send_byte(8'h78);
    send_byte(8'h00);
    send_byte(8'hAF);
    stop_c();
    check("t5_count", 32'(rx_cnt - n0), 32'd1);
    check("t5_data", 32'(rx_data), 32'hAF);
    // Read address
    n0 = rx_cnt;
    start_c();
    send_byte(8'h79);
`ifdef I2C_SLAVE_READ_EN
    check("t6_addr_ack", 32'(last_ack), 32'h0);
    read_byte(1'b0, v);
    check("t6_rd0", 32'(v), 32'hA5);
    read_byte(1'b1, v);
    check("t6_rd1", 32'(v), 32'hA5);
    send_byte(8'h00);
    check("t6_ignore", 32'(last_ack), 32'h1);
`else
    check("t6_addr_nack", 32'(last_ack), 32'h1);
    check("t6_busy", 32'(busy), 32'h0);
`endif
    stop_c();
    check("t6_count", 32'(rx_cnt - n0), 32'd0);
    // Randomized write transactions with occasional mid-byte aborts
    for (int t = 0; t < 20; t++) begin
      start_c();
      a = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
      send_byte({a, 1'b0});
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) send_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0) pbits(8'($urandom), $urandom_range(1, 7));
      else stop_c();
    end
    stop_c();
    tick(8);
    check("rx_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
